// File: rtl/mem_pkg.sv
// mem_pkg: widths and FSM encoding shared by the line responder and its RAM.
package mem_pkg;

  localparam int BEATS_PER_LINE = 8;
  localparam int LINE_ADDR_W    = 27;
  localparam int WORD_W         = 32;
  localparam int OFF_W          = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    WBURST = 3'd2,
    RBURST = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/mem_line_ram.sv
// mem_line_ram: single-port word RAM, one access per cycle, registered read.
// The read register holds its value unless a read is issued.
module mem_line_ram
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_line_responder.sv
// mem_line_responder: backing-memory side of the L1 line-fill / write-back port.
// Define MEMRESP_CRIT_WORD_FIRST_EN to start every burst at the critical word.
module mem_line_responder
  import mem_pkg::*;
#(
  parameter int LATENCY     = 20,
  parameter int DEPTH_WORDS = 1024,
  parameter int BEATS       = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req,
  input  logic                   req_wr,
  input  logic [LINE_ADDR_W-1:0] req_line,
  input  logic [OFF_W-1:0]       req_off,
  output logic                   ack,
  output logic                   busy,
  output logic                   wready,
  input  logic [WORD_W-1:0]      wdata,
  output logic                   rvalid,
  output logic [WORD_W-1:0]      rdata,
  output logic [OFF_W-1:0]       rbeat,
  output logic                   done
);

  localparam int               AW       = $clog2(DEPTH_WORDS);
  localparam logic [OFF_W-1:0] LAST     = OFF_W'(BEATS - 1);
  localparam logic [7:0]       CNT_INIT = 8'(LATENCY - 1);

  state_t                 state, state_n;
  logic [7:0]             cnt;
  logic [OFF_W-1:0]       beat;
  logic [OFF_W-1:0]       idx_sel;
  logic [OFF_W-1:0]       word_idx;
  logic                   wr_q;
  logic [LINE_ADDR_W-1:0] line_q;
  logic                   ram_we;
  logic                   ram_re;
  logic [AW-1:0]          ram_addr;

`ifdef MEMRESP_CRIT_WORD_FIRST_EN
  logic [OFF_W-1:0] off_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                    off_q <= '0;
    else if (state == IDLE && req) off_q <= req_off;
  end

  assign word_idx = off_q + idx_sel;
`else
  logic unused_off;

  assign unused_off = ^req_off;
  assign word_idx   = idx_sel;
`endif

  // Upper line bits fall off here, so addresses wrap modulo DEPTH_WORDS.
  assign ram_addr = AW'({line_q, word_idx});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (req) state_n = WAIT;
      WAIT:   if (cnt == '0) state_n = wr_q ? WBURST : RBURST;
      WBURST: if (beat == LAST) state_n = DONE;
      RBURST: if (beat == LAST) state_n = DONE;
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Reads run one cycle ahead of rvalid: the last WAIT cycle fetches beat 0.
  always_comb begin
    busy    = (state != IDLE);
    wready  = (state == WBURST);
    done    = (state == DONE);
    ram_we  = (state == WBURST);
    ram_re  = 1'b0;
    idx_sel = '0;
    unique case (1'b1)
      (state == WAIT): begin
        ram_re = (cnt == '0) && !wr_q;
      end
      (state == RBURST): begin
        ram_re  = (beat != LAST);
        idx_sel = beat + OFF_W'(1);
      end
      (state == WBURST): begin
        idx_sel = beat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack    <= 1'b0;
      wr_q   <= 1'b0;
      line_q <= '0;
      cnt    <= '0;
      beat   <= '0;
      rvalid <= 1'b0;
      rbeat  <= '0;
    end else begin
      ack    <= (state == IDLE) && req;
      rvalid <= ram_re;
      if (ram_re) rbeat <= word_idx;
      unique case (state)
        IDLE: begin
          if (req) begin
            wr_q   <= req_wr;
            line_q <= req_line;
            cnt    <= CNT_INIT;
            beat   <= '0;
          end
        end
        WAIT:    if (cnt != '0) cnt <= cnt - 8'd1;
        WBURST:  beat <= beat + OFF_W'(1);
        RBURST:  beat <= beat + OFF_W'(1);
        default: ;
      endcase
    end
  end

  mem_line_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clock(clock),
    .reset(reset),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(wdata),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_mem_line_responder.sv
// tb_mem_line_responder: directed write-back / refill sequences, LATENCY=4.
// Expected words and beat orders are hand-built tables per command.
module tb_mem_line_responder;

  localparam int LAT = 4;
`ifdef MEMRESP_CRIT_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        req_wr = 1'b0;
  logic [26:0] req_line = '0;
  logic [2:0]  req_off = '0;
  logic [31:0] wdata = '0;
  logic        ack, busy, wready, rvalid, done;
  logic [31:0] rdata;
  logic [2:0]  rbeat;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_w [8];

  always #5 clock = ~clock;

  mem_line_responder #(
    .LATENCY    (LAT),
    .DEPTH_WORDS(1024),
    .BEATS      (8)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .req_wr  (req_wr),
    .req_line(req_line),
    .req_off (req_off),
    .ack     (ack),
    .busy    (busy),
    .wready  (wready),
    .wdata   (wdata),
    .rvalid  (rvalid),
    .rdata   (rdata),
    .rbeat   (rbeat),
    .done    (done)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [2:0] idx_of(input logic [2:0] off, input int k);
    return CWF ? off + 3'(k) : 3'(k);
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_wready"}, wready, 0);
    check({tag, "_rvalid"}, rvalid, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_rbeat"}, rbeat, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 8; i++) exp_w[i] = base + 32'(i);
  endtask

  task automatic issue(input logic wr, input logic [26:0] line,
                       input logic [2:0] off);
    req      = 1'b1;
    req_wr   = wr;
    req_line = line;
    req_off  = off;
    step();
    check("ack", ack, 1);
    check("busy", busy, 1);
    req      = 1'b0;
    req_wr   = ~wr;
    req_line = ~line;
    req_off  = ~off;
  endtask

  task automatic wb_body(input logic [31:0] base, input int stop_at);
    int n = 1;
    while (!wready && n < 50) begin
      step();
      n++;
    end
    check("wb_lat", n, LAT + 1);
    for (int k = 0; k < 8; k++) begin
      wdata = base + 32'(k);
      if (k == stop_at) begin
        reset = 1'b1;
        #1;
        check_zero("rst_mid");
        return;
      end
      check("wready", wready, 1);
      step();
    end
    check("wb_done", done, 1);
    check("wb_wready_off", wready, 0);
    check("wb_busy_done", busy, 1);
    step();
    check("wb_idle_busy", busy, 0);
    check("wb_idle_done", done, 0);
  endtask

  task automatic rd_body(input logic [2:0] off, input bit poke, input bit hold);
    int n = 1;
    logic [2:0] i;
    while (!rvalid && n < 50) begin
      if (poke && n == 2) req = 1'b1;
      step();
      n++;
      if (poke && n == 3) begin
        check("ack_wait", ack, 0);
        req = 1'b0;
      end
    end
    check("rd_lat", n, LAT + 1);
    for (int k = 0; k < 8; k++) begin
      i = idx_of(off, k);
      check("rvalid", rvalid, 1);
      check("rbeat", rbeat, i);
      check("rdata", rdata, exp_w[i]);
      if (poke && k == 3) req = 1'b1;
      if (poke && k == 4) begin
        check("ack_burst", ack, 0);
        req = 1'b0;
      end
      if (hold && k == 7) begin
        req      = 1'b1;
        req_wr   = 1'b0;
        req_line = 27'd3;
        req_off  = 3'd0;
      end
      step();
    end
    check("rd_done", done, 1);
    check("rd_rvalid_off", rvalid, 0);
    check("rd_hold", rdata, exp_w[idx_of(off, 7)]);
    check("rd_busy_done", busy, 1);
    check("rd_ack_done", ack, 0);
    step();
    check("rd_idle_busy", busy, 0);
    check("rd_idle_done", done, 0);
    check("rd_idle_ack", ack, 0);
  endtask

  initial begin
    step();
    step();
    check_zero("reset");
    reset = 1'b0;
    step();

    issue(1'b1, 27'd100, 3'd0);
    wb_body(32'h100, 8);
    fill(32'h100);
    issue(1'b0, 27'd100, 3'd0);
    rd_body(3'd0, 1'b0, 1'b0);

    issue(1'b1, 27'd3, 3'd0);
    wb_body(32'hA0, 8);
    fill(32'hA0);
    issue(1'b0, 27'd3, 3'd0);
    rd_body(3'd0, 1'b0, 1'b0);

    fill(32'h100);
    issue(1'b0, 27'd100, 3'd5);
    rd_body(3'd5, 1'b1, 1'b1);
    step();
    check("held_ack", ack, 1);
    check("held_busy", busy, 1);
    req = 1'b0;
    fill(32'hA0);
    rd_body(3'd0, 1'b0, 1'b0);

    issue(1'b1, 27'd5, 3'd0);
    wb_body(32'h500, 8);
    issue(1'b1, 27'd5, 3'd0);
    wb_body(32'hC0, 3);
    step();
    check_zero("rst_hold");
    reset = 1'b0;
    step();
    fill(32'h500);
    exp_w[0] = 32'hC0;
    exp_w[1] = 32'hC1;
    exp_w[2] = 32'hC2;
    issue(1'b0, 27'd5, 3'd0);
    rd_body(3'd0, 1'b0, 1'b0);

    issue(1'b1, 27'h7FF_FFFF, 3'd0);
    wb_body(32'hE0, 8);
    fill(32'hE0);
    issue(1'b0, 27'h7FF_FFFF, 3'd0);
    rd_body(3'd0, 1'b0, 1'b0);
    issue(1'b0, 27'd127, 3'd0);
    rd_body(3'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
- Backing-memory side of the L1 line-fill/write-back interface.
- Accepts one line-sized command from the data cache: either a refill (read 8 words) or a write-back (write 8 words).
- Models main-memory access latency with a counter, then streams 8 beats, one word per cycle.
- Replaces the cache's internal fixed delay; the cache holds stall_me high until done.

Parameters:
- LATENCY, 20: cycles from command accept to first beat; legal range 1..255.
- DEPTH_WORDS, 1024: main-memory size in 32-bit words; power of two.
- BEATS, 8: words per line; fixed at 8, not intended to be overridden.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  command request from cache; sampled only in IDLE.
- req_wr  in  1  1 = write-back, 0 = refill; sampled with req.
- req_line  in  27  line address, i.e. byte address [31:5].
- req_off  in  3  critical word offset (addr[4:2]).
- ack  out  1  one-cycle pulse in the cycle after a req is accepted.
- busy  out  1  high from accept until done, inclusive.
- wready  out  1  write-back beat strobe; cache must present wdata in the same cycle.
- wdata  in  32  write-back data.
- rvalid  out  1  refill beat valid.
- rdata  out  32  refill data.
- rbeat  out  3  word index within line of the current rdata.
- done  out  1  one-cycle pulse after the last beat.

Behaviour:
- Reset values: ack=0, busy=0, wready=0, rvalid=0, rdata=0, rbeat=0, done=0, FSM=IDLE, counters=0. Memory array is not cleared by reset.
- FSM states: IDLE, WAIT, WBURST, RBURST, DONE.
- IDLE:
  - req=1 latches req_wr, req_line and req_off; next state WAIT with latency counter = LATENCY-1; ack=1 next cycle; busy=1.
  - req=0: stay in IDLE.
- WAIT:
  - Counter decrements each cycle.
  - At 0: go to WBURST if req_wr else RBURST; beat counter = 0.
- Beat word index:
  - Without the optional feature: idx = beat.
  - With it: see Optional Feature.
- Memory word address = ({line,3'b000} + idx) mod DEPTH_WORDS. Upper address bits are silently dropped (wrap-around).
- WBURST:
  - wready=1 for exactly 8 consecutive cycles.
  - Each cycle, mem[addr(idx)] <= wdata.
  - After beat 7: go to DONE.
- RBURST:
  - rvalid=1 for exactly 8 consecutive cycles, with rdata = mem[addr(idx)] and rbeat = idx, all registered outputs.
  - After beat 7: go to DONE.
  - rdata holds its last value when rvalid=0.
- DONE:
  - done=1 and busy=1 for one cycle, then IDLE with busy=0.
- Throughput: req is ignored (no ack) in every state except IDLE. Earliest next accept is the cycle after done. Total occupancy per command = 1 + LATENCY + 8 + 1 cycles.
- No back-pressure: the cache must accept or supply a beat every cycle the strobe is high.
- Reset asserted mid-command:
  - Immediately returns to IDLE and all outputs go to reset values.
  - Partially written words of an interrupted write-back remain written.
- req_wr, req_line and req_off changes after accept have no effect.
- Simulation: memory is optionally preloaded from the data and instruction files at the same base layout as the existing memory model (instructions at word 0, data at word 100).

Optional Feature:
- Macro: MEMRESP_CRIT_WORD_FIRST_EN.
- Defined: idx = (req_off + beat) mod 8, for both read and write bursts. rbeat reports the true word index, so the first refill beat is the critical word.
- Undefined: idx = beat (0..7 in order); req_off is ignored.

Decomposition:
- Shared package mem_pkg holds:
  - BEATS_PER_LINE=8
  - LINE_ADDR_W=27
  - WORD_W=32
  - OFF_W=3
  - the state encoding: IDLE=0, WAIT=1, WBURST=2, RBURST=3, DONE=4
- One natural sub-module: mem_line_ram, a single-port synchronous word RAM (DEPTH_WORDS x 32, one read or write per cycle, registered read) that holds the array and the simulation preload.

Test Plan:
1. Preload mem[800+i] = 0x100+i, i = 0..7; refill req_line=100, req_off=0, LATENCY=4 -> ack the cycle after req; first rvalid 5 cycles after accept; rdata 0x100..0x107 with rbeat 0..7; done 1 cycle later; busy low the next cycle.
2. Write-back req_line=3, wdata = 0xA0+beat while wready -> mem[24..31] = 0xA0..0xA7. A following refill of line 3 returns the same values.
3. With MEMRESP_CRIT_WORD_FIRST_EN, refill line 100 with req_off=5 -> rbeat sequence 5,6,7,0,1,2,3,4; rdata 0x105,0x106,0x107,0x100,…,0x104. Without the macro: 0..7 in order.
4. Pulse req during WAIT and during RBURST -> no ack and no new command. A req held high across done is accepted the cycle after done.
5. Assert reset at beat 3 of a write-back -> all outputs 0 and FSM in IDLE at once; mem words for beats 0..2 updated, beats 3..7 unchanged.
6. req_line = 0x7FFFFFF with DEPTH_WORDS=1024 -> accesses words 1016..1023 (address wraps); no X on rdata.
